// File: rtl/uart_rx_ext_pkg.sv
// Shared definitions for the uart_rx_ext receiver: FSM states, parity and
// stop-bit codes, minimum data-field width and config normalisation helpers.
package uart_rx_ext_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } state_t;

   localparam logic [2:0] PAR_NONE  = 3'd0;
   localparam logic [2:0] PAR_EVEN  = 3'd1;
   localparam logic [2:0] PAR_ODD   = 3'd2;
   localparam logic [2:0] PAR_MARK  = 3'd3;
   localparam logic [2:0] PAR_SPACE = 3'd4;

   localparam logic [1:0] STOP_ONE      = 2'd0;
   localparam logic [1:0] STOP_ONE_HALF = 2'd1;
   localparam logic [1:0] STOP_TWO      = 2'd2;

   localparam logic [3:0] DBIT_MIN = 4'd5;

   // Requested data width forced into DBIT_MIN..max_bits.
   function automatic logic [3:0] clamp_bits(input logic [3:0] req, input logic [3:0] max_bits);
      if (req < DBIT_MIN) return DBIT_MIN;
      if (req > max_bits) return max_bits;
      return req;
   endfunction

   // Unused parity codes behave as "no parity".
   function automatic logic [2:0] norm_parity(input logic [2:0] mode);
      return (mode > PAR_SPACE) ? PAR_NONE : mode;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchroniser (idle-high reset), 3-sample centre
// window and majority vote. Optional UART_RX_NOISE_EN adds the disagreement
// flag used for noise reporting.
module uart_rx_sampler #(
   parameter int unsigned OVS = 16,
   parameter int unsigned SW  = $clog2(OVS)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          rx,
   input  logic          s_tick,
   input  logic [SW-1:0] s,
   output logic          rxs,
`ifdef UART_RX_NOISE_EN
   output logic          disagree,
`endif
   output logic          vote
);

   localparam logic [SW-1:0] S_FIRST = SW'(OVS/2 - 1);
   localparam logic [SW-1:0] S_MID   = SW'(OVS/2);

   logic       sync1, sync2;
   logic [1:0] win;

   // Synchronise the asynchronous line; reset to idle so no false start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= rx;
         sync2 <= sync1;
      end
   end

   assign rxs = sync2;

   // Hold the first two centre samples; the third is the live rxs at decision.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         win <= '1;
      end else if (s_tick && (s == S_FIRST || s == S_MID)) begin
         win <= {win[0], rxs};
      end
   end

   // Majority of the three samples, valid on the tick where s = OVS/2+1.
   always_comb begin
      vote = (win[1] & win[0]) | (win[1] & rxs) | (win[0] & rxs);
`ifdef UART_RX_NOISE_EN
      disagree = !((win[1] == win[0]) && (win[0] == rxs));
`endif
   end

endmodule

// File: rtl/uart_rx_ext.sv
// Configurable UART receiver: 5..DBIT_MAX data bits, none/even/odd/mark/space
// parity, 1/1.5/2 stop bits, majority voting, false-start and break detection,
// valid/ready output register with sticky overrun.
// Optional macro UART_RX_NOISE_EN adds the noise_flag output.
module uart_rx_ext
   import uart_rx_ext_pkg::*;
#(
   parameter int unsigned DBIT_MAX = 9,
   parameter int unsigned OVS      = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                rx,
   input  logic                s_tick,
   input  logic [3:0]          data_bits,
   input  logic [2:0]          parity_mode,
   input  logic [1:0]          stop_bits,
   output logic [DBIT_MAX-1:0] dout,
   output logic                dout_valid,
   input  logic                dout_ready,
   output logic                parity_error,
   output logic                frame_error,
   output logic                break_det,
   output logic                overrun,
   input  logic                err_clr
`ifdef UART_RX_NOISE_EN
   ,
   output logic                noise_flag
`endif
);

   localparam int unsigned   SW     = $clog2(OVS);
   localparam logic [SW-1:0] S_DEC  = SW'(OVS/2 + 1);
   localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);

   state_t              state, state_nx;
   logic [SW-1:0]       s;
   logic [3:0]          n, nb;
   logic [2:0]          pmode;
   logic                two_stop, stop2;
   logic [DBIT_MAX-1:0] b;
   logic                perr, ferr, all_zero;
   logic                rxs, vote;
   logic                decide, bit_end, final_stop, ferr_final;
   logic                start_frame, complete, brk, load;
`ifdef UART_RX_NOISE_EN
   logic                disagree, noise;
`endif

   uart_rx_sampler #(.OVS(OVS), .SW(SW)) u_sampler (
      .clk      (clk),
      .reset_n  (reset_n),
      .rx       (rx),
      .s_tick   (s_tick),
      .s        (s),
      .rxs      (rxs),
`ifdef UART_RX_NOISE_EN
      .disagree (disagree),
`endif
      .vote     (vote)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nx;
   end

   // Next state and per-clk frame strobes.
   always_comb begin
      state_nx    = state;
      start_frame = 1'b0;
      complete    = 1'b0;
      brk         = 1'b0;
      decide      = s_tick && (s == S_DEC);
      bit_end     = s_tick && (s == S_LAST);
      final_stop  = decide && (stop2 || !two_stop);
      ferr_final  = stop2 ? (ferr | ~vote) : ~vote;
      case (state)
         ST_IDLE: if (!rxs) begin
            state_nx    = ST_START;
            start_frame = 1'b1;
         end
         ST_START: begin
            if (decide && vote) state_nx = ST_IDLE;
            else if (bit_end)   state_nx = ST_DATA;
         end
         ST_DATA: if (bit_end && n == nb - 4'd1) begin
            state_nx = (pmode == PAR_NONE) ? ST_STOP : ST_PARITY;
         end
         ST_PARITY: if (bit_end) state_nx = ST_STOP;
         ST_STOP: if (final_stop) begin
            if (all_zero && !vote) begin
               brk      = 1'b1;
               state_nx = ST_BREAK;
            end else begin
               complete = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         ST_BREAK: if (rxs) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
      load = complete && (!dout_valid || dout_ready);
   end

   // Frame datapath: tick counter, bit index, config latch, shift-in and checks.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s        <= '0;
         n        <= '0;
         nb       <= '0;
         pmode    <= '0;
         two_stop <= 1'b0;
         stop2    <= 1'b0;
         b        <= '0;
         perr     <= 1'b0;
         ferr     <= 1'b0;
         all_zero <= 1'b0;
`ifdef UART_RX_NOISE_EN
         noise    <= 1'b0;
`endif
      end else if (start_frame) begin
         s        <= '0;
         n        <= '0;
         nb       <= clamp_bits(data_bits, 4'(DBIT_MAX));
         pmode    <= norm_parity(parity_mode);
         two_stop <= (stop_bits >= STOP_TWO);
         stop2    <= 1'b0;
         b        <= '0;
         perr     <= 1'b0;
         ferr     <= 1'b0;
         all_zero <= 1'b1;
`ifdef UART_RX_NOISE_EN
         noise    <= 1'b0;
`endif
      end else if (s_tick && state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}) begin
         s <= (s == S_LAST) ? '0 : s + 1'b1;
         if (decide && state != ST_START) all_zero <= all_zero & ~vote;
`ifdef UART_RX_NOISE_EN
         if (decide) noise <= noise | disagree;
`endif
         case (state)
            ST_DATA: begin
               if (decide) begin
                  for (int unsigned i = 0; i < DBIT_MAX; i++) begin
                     if (n == 4'(i)) b[i] <= vote;
                  end
               end
               if (bit_end) n <= n + 4'd1;
            end
            ST_PARITY: if (decide) begin
               case (pmode)
                  PAR_EVEN:  perr <= ^b ^ vote;
                  PAR_ODD:   perr <= ~(^b ^ vote);
                  PAR_MARK:  perr <= ~vote;
                  PAR_SPACE: perr <= vote;
                  default:   perr <= 1'b0;
               endcase
            end
            ST_STOP: begin
               if (decide)  ferr  <= ferr_final;
               if (bit_end) stop2 <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Output register, handshake, break reporting and sticky overrun.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dout         <= '0;
         dout_valid   <= 1'b0;
         parity_error <= 1'b0;
         frame_error  <= 1'b0;
         break_det    <= 1'b0;
         overrun      <= 1'b0;
`ifdef UART_RX_NOISE_EN
         noise_flag   <= 1'b0;
`endif
      end else begin
         break_det <= brk;
         if (load) begin
            dout         <= b;
            parity_error <= perr;
            frame_error  <= ferr_final;
            dout_valid   <= 1'b1;
`ifdef UART_RX_NOISE_EN
            noise_flag   <= noise | disagree;
`endif
         end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
         end
         if (brk) frame_error <= 1'b1;
         if (complete && !load) overrun <= 1'b1;
         else if (err_clr)      overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Randomised bench for uart_rx_ext (OVS=16, DBIT_MAX=9) with a frame-level
// reference model; noise_flag is checked when UART_RX_NOISE_EN is defined.
module tb_uart_rx_ext;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       rx = 1'b1;
   logic       s_tick;
   logic [3:0] data_bits = 4'd8;
   logic [2:0] parity_mode = 3'd0;
   logic [1:0] stop_bits = 2'd0;
   logic [8:0] dout;
   logic       dout_valid;
   logic       dout_ready = 1'b1;
   logic       parity_error, frame_error, break_det, overrun;
   logic       err_clr = 1'b0;
`ifdef UART_RX_NOISE_EN
   logic       noise_flag;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [8:0] d;
      logic       pe;
      logic       fe;
      logic       nf;
   } obs_t;

   obs_t mon_q[$];
   int   brk_cnt = 0;

   uart_rx_ext #(.DBIT_MAX(9), .OVS(16)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .rx           (rx),
      .s_tick       (s_tick),
      .data_bits    (data_bits),
      .parity_mode  (parity_mode),
      .stop_bits    (stop_bits),
      .dout         (dout),
      .dout_valid   (dout_valid),
      .dout_ready   (dout_ready),
      .parity_error (parity_error),
      .frame_error  (frame_error),
      .break_det    (break_det),
      .overrun      (overrun),
      .err_clr      (err_clr)
`ifdef UART_RX_NOISE_EN
      ,
      .noise_flag   (noise_flag)
`endif
   );

   always #5 clk = ~clk;

   // Baud tick: one clk in four.
   logic [1:0] tcnt = 2'd0;
   always @(posedge clk) tcnt <= tcnt + 2'd1;
   assign s_tick = (tcnt == 2'd3);

   // Record every accepted word and every break pulse.
   always @(negedge clk) begin
      obs_t o;
      if (reset_n && dout_valid && dout_ready) begin
         o.d  = dout;
         o.pe = parity_error;
         o.fe = frame_error;
`ifdef UART_RX_NOISE_EN
         o.nf = noise_flag;
`else
         o.nf = 1'b0;
`endif
         mon_q.push_back(o);
      end
      if (reset_n && break_det) brk_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic wait_tick();
      do @(negedge clk); while (!s_tick);
   endtask

   // One bit time; optional single-tick inversion at the bit centre.
   task automatic drive_bit(input logic v, input bit glitch);
      rx = v;
      repeat (8) wait_tick();
      if (glitch) rx = ~v;
      wait_tick();
      rx = v;
      repeat (7) wait_tick();
   endtask

   // Build a frame from the line rules, send it, and compare with the model.
   task automatic run_frame(input string tag, input logic [3:0] db, input logic [2:0] pm,
                            input logic [1:0] sb, input logic [8:0] data, input bit bad_par,
                            input bit bad_s1, input bit bad_s2, input int gbit, input bit do_check);
      int         nb, pm_e, ones;
      bit         two, brk, pb;
      logic [8:0] dm;
      bit         bits[$];
      obs_t       o;
      nb   = (db < 4'd5) ? 5 : (db > 4'd9) ? 9 : int'(db);
      pm_e = (pm > 3'd4) ? 0 : int'(pm);
      two  = (sb >= 2'd2);
      dm   = data & 9'((1 << nb) - 1);
      ones = $countones(dm);
      bits.push_back(1'b0);
      for (int i = 0; i < nb; i++) bits.push_back(dm[i]);
      if (pm_e != 0) begin
         case (pm_e)
            1:       pb = (ones % 2 == 1);
            2:       pb = (ones % 2 == 0);
            3:       pb = 1'b1;
            default: pb = 1'b0;
         endcase
         bits.push_back(pb ^ bad_par);
      end
      bits.push_back(!bad_s1);
      if (two) bits.push_back(!bad_s2);
      brk = 1'b1;
      for (int i = 1; i < bits.size(); i++) if (bits[i]) brk = 1'b0;

      data_bits   = db;
      parity_mode = pm;
      stop_bits   = sb;
      if (do_check) begin
         mon_q.delete();
         brk_cnt = 0;
      end
      for (int i = 0; i < bits.size(); i++) begin
         if (i == bits.size() - 1 && !bits[i]) begin
            rx = 1'b0;
            repeat (12) wait_tick();
            rx = 1'b1;
            repeat (4) wait_tick();
         end else begin
            drive_bit(bits[i], gbit >= 0 && i == gbit + 1);
         end
      end
      rx = 1'b1;
      repeat (16) wait_tick();

      if (do_check) begin
         if (brk) begin
            check_eq({tag, "_push"}, mon_q.size(), 0);
            check_eq({tag, "_brk"}, brk_cnt, 1);
            check_eq({tag, "_fe"}, {31'd0, frame_error}, 1);
         end else begin
            check_eq({tag, "_push"}, mon_q.size(), 1);
            check_eq({tag, "_brk"}, brk_cnt, 0);
            if (mon_q.size() > 0) begin
               o = mon_q.pop_front();
               check_eq({tag, "_dout"}, {23'd0, o.d}, {23'd0, dm});
               check_eq({tag, "_pe"}, {31'd0, o.pe}, {31'd0, (bad_par && pm_e != 0)});
               check_eq({tag, "_fe"}, {31'd0, o.fe}, {31'd0, (bad_s1 || (two && bad_s2))});
`ifdef UART_RX_NOISE_EN
               check_eq({tag, "_nf"}, {31'd0, o.nf}, {31'd0, (gbit >= 0)});
`endif
            end
         end
         check_eq({tag, "_vld"}, {31'd0, dout_valid}, 0);
      end
   endtask

   initial begin
      int         nb;
      logic [3:0] db;
      logic [2:0] pm;
      logic [1:0] sb;
      logic [8:0] d;
      bit         bp, b1, b2;
      int         g;

      repeat (5) @(negedge clk);
      check_eq("rst_dout", {23'd0, dout}, 0);
      check_eq("rst_vld", {31'd0, dout_valid}, 0);
      check_eq("rst_pe", {31'd0, parity_error}, 0);
      check_eq("rst_fe", {31'd0, frame_error}, 0);
      check_eq("rst_brk", {31'd0, break_det}, 0);
      check_eq("rst_ovr", {31'd0, overrun}, 0);
      reset_n = 1'b1;
      repeat (20) wait_tick();

      run_frame("8n1_a5", 4'd8, 3'd0, 2'd0, 9'h0A5, 0, 0, 0, -1, 1);
      run_frame("7e1_bad", 4'd7, 3'd1, 2'd0, 9'h041, 1, 0, 0, -1, 1);
      run_frame("7e1_ok", 4'd7, 3'd1, 2'd0, 9'h041, 0, 0, 0, -1, 1);

      // False start: short low pulse must not produce anything.
      mon_q.delete();
      brk_cnt = 0;
      rx = 1'b0;
      repeat (5) wait_tick();
      rx = 1'b1;
      repeat (40) wait_tick();
      check_eq("fs_push", mon_q.size(), 0);
      check_eq("fs_vld", {31'd0, dout_valid}, 0);
      check_eq("fs_brk", brk_cnt, 0);

      run_frame("glitch55", 4'd8, 3'd0, 2'd0, 9'h055, 0, 0, 0, 2, 1);

      // Long break, then a normal frame.
      data_bits   = 4'd8;
      parity_mode = 3'd0;
      stop_bits   = 2'd0;
      mon_q.delete();
      brk_cnt = 0;
      rx = 1'b0;
      repeat (12 * 16) wait_tick();
      check_eq("brk_cnt", brk_cnt, 1);
      check_eq("brk_fe", {31'd0, frame_error}, 1);
      check_eq("brk_vld", {31'd0, dout_valid}, 0);
      rx = 1'b1;
      repeat (16) wait_tick();
      run_frame("after_brk", 4'd8, 3'd0, 2'd0, 9'h03C, 0, 0, 0, -1, 1);

      // Overrun with consumer stalled, then clear.
      dout_ready = 1'b0;
      run_frame("ov1", 4'd8, 3'd0, 2'd0, 9'h011, 0, 0, 0, -1, 0);
      run_frame("ov2", 4'd8, 3'd0, 2'd0, 9'h022, 0, 0, 0, -1, 0);
      check_eq("ov_dout", {23'd0, dout}, 32'h011);
      check_eq("ov_vld", {31'd0, dout_valid}, 1);
      check_eq("ov_set", {31'd0, overrun}, 1);
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check_eq("ov_clr", {31'd0, overrun}, 0);
      check_eq("ov_hold", {23'd0, dout}, 32'h011);
      run_frame("ov3", 4'd8, 3'd0, 2'd0, 9'h033, 0, 0, 0, -1, 0);
      check_eq("ov_set2", {31'd0, overrun}, 1);

      // Reset in the middle of a 9O2 data field.
      data_bits   = 4'd9;
      parity_mode = 3'd2;
      stop_bits   = 2'd2;
      drive_bit(1'b0, 0);
      repeat (3) drive_bit(1'b1, 0);
      repeat (4) wait_tick();
      reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq("mrst_dout", {23'd0, dout}, 0);
      check_eq("mrst_vld", {31'd0, dout_valid}, 0);
      check_eq("mrst_ovr", {31'd0, overrun}, 0);
      check_eq("mrst_fe", {31'd0, frame_error}, 0);
      check_eq("mrst_pe", {31'd0, parity_error}, 0);
      reset_n    = 1'b1;
      dout_ready = 1'b1;
      rx         = 1'b1;
      repeat (40) wait_tick();
      run_frame("9o2_1ff", 4'd9, 3'd2, 2'd2, 9'h1FF, 0, 0, 0, -1, 1);

      // Consumer wakes before the second word completes: no overrun.
      mon_q.delete();
      dout_ready = 1'b0;
      run_frame("rd1", 4'd8, 3'd0, 2'd0, 9'h011, 0, 0, 0, -1, 0);
      dout_ready = 1'b1;
      run_frame("rd2", 4'd8, 3'd0, 2'd0, 9'h022, 0, 0, 0, -1, 0);
      check_eq("rd_n", mon_q.size(), 2);
      if (mon_q.size() == 2) begin
         check_eq("rd_w0", {23'd0, mon_q[0].d}, 32'h011);
         check_eq("rd_w1", {23'd0, mon_q[1].d}, 32'h022);
      end
      check_eq("rd_ovr", {31'd0, overrun}, 0);

      // Random formats, words, line errors and glitches.
      for (int k = 0; k < 30; k++) begin
         db = 4'($urandom_range(0, 15));
         pm = 3'($urandom_range(0, 7));
         sb = 2'($urandom_range(0, 3));
         d  = 9'($urandom);
         bp = ($urandom_range(0, 3) == 0);
         b1 = ($urandom_range(0, 5) == 0);
         b2 = ($urandom_range(0, 5) == 0);
         nb = (db < 4'd5) ? 5 : (db > 4'd9) ? 9 : int'(db);
         g  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
         if (k % 7 == 3) begin
            d  = 9'd0;
            bp = 1'b0;
            b1 = 1'b1;
            b2 = 1'b1;
         end
         run_frame($sformatf("rnd%0d", k), db, pm, sb, d, bp, b1, b2, g, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_ext.md
Name: uart_rx_ext

Overview:
- Next-generation UART receiver for the serial/VGA game link. Oversamples `rx` on the shared baud tick `s_tick`.
- Runtime-configurable frame format:
  - 5..DBIT_MAX data bits
  - parity: none, even, odd, mark or space
  - 1, 1.5 or 2 stop bits
- Adds 3-sample majority voting, false-start rejection, break detection, and a valid/ready output register with overrun flag.
- Sits between the baud generator and the game-command decoder.

Parameters:
- DBIT_MAX, 9, widest data field supported; dout width.
- OVS, 16, s_tick pulses per bit; even, at least 8.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rx  in  1  serial line, asynchronous, idle high
- s_tick  in  1  oversample enable, one-clk pulse
- data_bits  in  4  data bit count 5..DBIT_MAX; values outside this range are clamped
- parity_mode  in  3  0 none, 1 even, 2 odd, 3 mark, 4 space; 5-7 treated as none
- stop_bits  in  2  0 one, 1 one-and-half, 2 or 3 two
- dout  out  DBIT_MAX  received word, LSB-aligned, unused upper bits 0
- dout_valid  out  1  dout holds an unconsumed word
- dout_ready  in  1  consumer accepts dout
- parity_error  out  1  parity error of the word in dout
- frame_error  out  1  stop-bit error of the word in dout, or of the last break
- break_det  out  1  one-clk pulse on break detection
- overrun  out  1  sticky; a completed word was dropped
- err_clr  in  1  synchronous clear of overrun

Behaviour:
- Reset values:
  - all outputs 0
  - state IDLE, counters 0
  - both stages of the 2-flop rx synchroniser reset to 1, so reset never causes a false start
- All logic below uses the synchronised rx (rxs).
- Tick counter s runs 0..OVS-1 per bit period and advances only on s_tick.
- Each bit is decided by majority of rxs sampled at s = OVS/2-1, OVS/2 and OVS/2+1. The decision is made on the tick where s = OVS/2+1.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - rxs==0 → START with s=0.
  - Latch data_bits (clamped), parity_mode and stop_bits. Config changes mid-frame are ignored.
- START:
  - vote==1 → IDLE (false start; no flags).
  - Otherwise, at s=OVS-1 → DATA with bit index n=0.
- DATA:
  - At the decision point, write the vote into b[n]. Bits arrive LSB first.
  - At s=OVS-1: if n==latched_bits-1, go to PARITY (or STOP if parity is none); else n+1.
- PARITY:
  - At the decision point, set perr:
    - even: XOR(data, bit)==1
    - odd: XOR==0
    - mark: bit==0
    - space: bit==1
  - At s=OVS-1 → STOP.
- STOP:
  - At the first stop-bit decision point, ferr = ~vote.
  - For two stop bits, continue one more OVS period, and the second vote is ORed into ferr.
  - At the final stop decision point, go to IDLE without waiting for the bit to end. This allows back-to-back frames.
  - One-and-half stop bits is checked as one stop bit.
- Break: at the final stop decision, if all data, parity and stop votes were 0:
  - pulse break_det and set frame_error=1
  - no word is pushed
  - go to BREAK, which returns to IDLE once rxs==1
- Completion (non-break), in the same clk as the final stop decision:
  - If dout_valid==0, or dout_ready==1 in that clk: load dout, parity_error and frame_error; dout_valid=1.
  - Otherwise keep the old word and flags, and set overrun=1.
- Handshake:
  - dout_valid clears on the clk where dout_valid && dout_ready, unless a load occurs in that same clk.
  - dout is stable while dout_valid==1.
- Overrun clears on err_clr. If err_clr and a new overrun occur in the same clk, the set wins.
- Asynchronous reset mid-frame aborts the frame; nothing is pushed.

Optional Feature:
- Macro UART_RX_NOISE_EN.
- Defined:
  - adds output noise_flag (1 bit, reset 0), loaded alongside dout
  - noise_flag = 1 if any of the three votes disagreed for any bit of that frame (start through stop)
- Undefined: the port and its logic are absent; voting is unchanged.

Decomposition:
- Package/include uart_defs holds:
  - state encodings
  - parity_mode codes (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE)
  - stop_bits codes
  - data_bits min of 5
- One sub-module, uart_rx_sampler:
  - contains the rx synchroniser, the 3-sample shift register and majority output
  - flags vote disagreement
  - driven by s_tick and s

Test Plan (OVS=16, DBIT_MAX=9):
- 8N1, byte 0xA5, dout_ready=1 → dout=0x0A5, dout_valid one clk, parity_error=0, frame_error=0.
- 7E1, 0x41 sent with parity bit 1 → dout=0x041, parity_error=1. Same frame with parity 0 → parity_error=0.
- Glitches rejected:
  - rx low for 5 ticks then high → no dout_valid, state back to IDLE
  - 1-tick low pulse at the centre of a data bit in 0x55 → dout=0x055
  - with UART_RX_NOISE_EN, the same glitch gives noise_flag=1
- rx held low for 12 bit times → break_det pulse, frame_error=1, dout_valid stays 0; next 8N1 0x3C after rx goes high is received correctly.
- Two 8N1 frames (0x11, 0x22) with dout_ready=0 → dout=0x011, overrun=1. err_clr → overrun=0. dout_ready=1 at the second completion instead → dout=0x022, overrun=0.
- 9O2 with word 0x1FF; reset_n pulsed low mid-DATA → outputs 0, next full frame received correctly with dout=0x1FF.
